// File: rtl/led_seq_pkg.sv
// Shared mode encodings, entry patterns and pattern helpers
// for the button-driven LED mode sequencer.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_CHASE = 2'd3
   } mode_e;

   localparam logic [2:0] LED_OFF     = 3'b000;
   localparam logic [2:0] BLINK_ENTRY = 3'b111;
   localparam logic [2:0] CHASE_ENTRY = 3'b001;

   function automatic mode_e next_mode(input mode_e m);
      unique case (m)
         MODE_OFF:   return MODE_BLINK;
         MODE_BLINK: return MODE_COUNT;
         MODE_COUNT: return MODE_CHASE;
         default:    return MODE_OFF;
      endcase
   endfunction

   function automatic logic [2:0] entry_led(input mode_e m);
      unique case (m)
         MODE_BLINK: return BLINK_ENTRY;
         MODE_CHASE: return CHASE_ENTRY;
         default:    return LED_OFF;
      endcase
   endfunction

   function automatic logic [2:0] advance_led(
      input mode_e      m,
      input logic [2:0] cur
   );
      unique case (m)
         MODE_BLINK: return (cur == BLINK_ENTRY) ? LED_OFF : BLINK_ENTRY;
         MODE_COUNT: return cur + 3'd1;
         MODE_CHASE: return {cur[1:0], cur[2]};
         default:    return LED_OFF;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser, debouncer and one-cycle press pulse
// generated on the rising edge of the debounced level.
module btn_debounce
   import led_seq_pkg::*;
#(
   parameter int DB_CYCLES = 240_000
) (
   input  logic clk,
   input  logic rst,
   input  logic button_in,
   output logic press_out
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         level     <= 1'b0;
         level_d1  <= 1'b0;
         cnt       <= '0;
         press_out <= 1'b0;
      end else begin
         sync1     <= button_in;
         sync2     <= sync1;
         level_d1  <= level;
         press_out <= level & ~level_d1;
         // Level flips only after a full run of disagreeing samples
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/led_mode_sequencer.sv
// Mode FSM, tick prescaler and LED pattern generator driven by
// debounced button presses.
module led_mode_sequencer
   import led_seq_pkg::*;
#(
   parameter int CLK_DIV   = 12_000_000,
   parameter int DB_CYCLES = 240_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   output logic [2:0] led,
   output logic [1:0] mode,
   output logic       tick
);

   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

   logic          press;
   mode_e         mode_q;
   mode_e         mode_d;
   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic [2:0]    led_q;
   logic [2:0]    led_d;
   logic          tc_q;
   logic          tc_d;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn (
      .clk       (clk),
      .rst       (rst),
      .button_in (button),
      .press_out (press)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= MODE_OFF;
      end else begin
         mode_q <= mode_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (press) begin
         mode_d = next_mode(mode_q);
      end
   end

   // A press landing on terminal count wins over the tick
   assign tick = tc_q & ~press;

   always_comb begin
      presc_d = '0;
      if (!press && mode_q != MODE_OFF && presc_q != PS_LAST) begin
         presc_d = presc_q + PW'(1);
      end
      led_d = led_q;
      unique case (1'b1)
         press:   led_d = entry_led(mode_d);
         tick:    led_d = advance_led(mode_q, led_q);
         default: led_d = led_q;
      endcase
      tc_d = (presc_d == PS_LAST) && (mode_d != MODE_OFF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         led_q   <= LED_OFF;
         tc_q    <= 1'b0;
      end else begin
         presc_q <= presc_d;
         led_q   <= led_d;
         tc_q    <= tc_d;
      end
   end

   assign led  = led_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Scoreboard bench for led_mode_sequencer: a reference model predicts
// every output event and a monitor compares the DUT against it.
module tb_led_mode_sequencer;

   localparam int CLK_DIV   = 4;
   localparam int DB_CYCLES = 3;

   logic       clk;
   logic       rst;
   logic       button;
   logic [2:0] led;
   logic [1:0] mode;
   logic       tick;

   typedef struct {
      int cyc;
      int mode;
      int led;
      bit tick;
   } ev_t;

   ev_t exp_q[$];
   bit  raw_q[$];

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   int m_mode  = 0;
   int m_led   = 0;
   int m_p     = -100;
   bit m_press = 0;
   bit m_rose  = 0;
   bit m_lvl   = 0;
   bit m_tick  = 0;

   led_mode_sequencer #(
      .CLK_DIV   (CLK_DIV),
      .DB_CYCLES (DB_CYCLES)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .button (button),
      .led    (led),
      .mode   (mode),
      .tick   (tick)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int entry_of(input int md);
      case (md)
         1:       return 7;
         3:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int adv_of(input int md, input int cur);
      case (md)
         1:       return (cur == 7) ? 0 : 7;
         2:       return (cur + 1) % 8;
         3:       return (cur == 4) ? 1 : cur * 2;
         default: return 0;
      endcase
   endfunction

   // Reference model: state after each rising edge
   initial begin
      int pm;
      int pl;
      pm = 0;
      pl = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_mode  = 0;
            m_led   = 0;
            m_press = 0;
            m_rose  = 0;
            m_lvl   = 0;
            m_tick  = 0;
            raw_q.delete();
            repeat (5) raw_q.push_back(1'b0);
         end else begin
            if (m_press) begin
               m_mode = (m_mode + 1) % 4;
               m_led  = entry_of(m_mode);
               m_p    = cyc - 1;
            end else if (m_tick) begin
               m_led = adv_of(m_mode, m_led);
            end
            m_press = m_rose;
            raw_q.push_back(button);
            m_rose = 0;
            if (raw_q[$-2] != m_lvl && raw_q[$-3] != m_lvl &&
                raw_q[$-4] != m_lvl) begin
               m_lvl  = !m_lvl;
               m_rose = m_lvl;
            end
            m_tick = (m_mode != 0) && (cyc > m_p) &&
                     ((cyc - m_p) % CLK_DIV == 0) && !m_press;
         end
         if (m_tick || m_mode != pm || m_led != pl)
            exp_q.push_back('{cyc, m_mode, m_led, m_tick});
         pm = m_mode;
         pl = m_led;
      end
   end

   // Monitor: any tick or change of led/mode is an event
   initial begin
      int  pmo;
      int  plo;
      bit  ev;
      ev_t e;
      pmo = 0;
      plo = 0;
      forever begin
         @(negedge clk);
         ev = (tick !== 1'b0) || (mode !== 2'(pmo)) || (led !== 3'(plo));
         if (ev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event cyc=%0d got mode=%0d led=%b tick=%b required no event",
                        cyc, mode, led, tick);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.mode != int'(mode) ||
                   e.led != int'(led) || e.tick != tick) begin
                  errors++;
                  $display("FAIL event cyc=%0d got mode=%0d led=%b tick=%b required cyc=%0d mode=%0d led=%0d tick=%0d",
                           cyc, mode, led, tick, e.cyc, e.mode, e.led, e.tick);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL missed_event cyc=%0d got mode=%0d led=%b tick=%b required mode=%0d led=%0d tick=%0d",
                     cyc, mode, led, tick, e.mode, e.led, e.tick);
         end
         pmo = int'(mode);
         plo = int'(led);
      end
   end

   task automatic drive(input logic b, input logic r);
      @(negedge clk);
      button = b;
      rst    = r;
   endtask

   task automatic hold(input logic b, input int n);
      repeat (n) drive(b, 1'b0);
   endtask

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", name, got, req);
      end
   endtask

   initial begin
      rst    = 1'b1;
      button = 1'b0;
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      chk("reset_led", int'(led), 0);
      chk("reset_mode", int'(mode), 0);
      chk("reset_tick", int'(tick), 0);
      hold(1'b0, 50);

      // first press into BLINK, held then released
      hold(1'b1, 20);
      hold(1'b0, 10);

      // glitch, then bounce followed by a steady level
      hold(1'b1, 2);
      hold(1'b0, 8);
      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      hold(1'b1, 10);
      hold(1'b0, 40);

      // third press into CHASE
      hold(1'b1, 8);
      hold(1'b0, 16);

      // fourth press aligned with terminal count
      for (int k = 0; k < 8 && ((cyc + 7 - m_p) % CLK_DIV) != 0; k++)
         drive(1'b0, 1'b0);
      hold(1'b1, 8);
      hold(1'b0, 20);

      // back to CHASE, then reset with the button held
      for (int k = 0; k < 3; k++) begin
         hold(1'b1, 8);
         hold(1'b0, 12);
      end
      hold(1'b0, 6);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      hold(1'b1, 15);
      hold(1'b0, 10);

      // randomized button activity with occasional reset
      for (int k = 0; k < 250; k++) begin
         logic b;
         b = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 40) == 0) begin
            drive(b, 1'b1);
         end else begin
            hold(b, $urandom_range(1, 12));
         end
      end
      hold(1'b0, 20);

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
